serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer: time-shares one full_adder cell over WIDTH cycles
//  to add two WIDTH-bit operands plus carry-in. It replaces a WIDTH-cell ripple chain.

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/serial_add_ctrl_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM encoding and sizing helpers.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell, purely combinational.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell reused over WIDTH cycles, LSB first.
// Start accepted at edge k gives a one-cycle done after edge k+WIDTH; start outside IDLE is dropped.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             busy_d;
    logic             done_d;
    logic             fa_y;
    logic             fa_cout;
    logic [WIDTH-1:0] y_msb;

    full_adder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .Y    (fa_y),
        .Cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands in sum[0].
    assign y_msb    = WIDTH'(fa_y) << (WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (last_bit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status is decoded from the next state and registered, keeping outputs flop-driven.
    always_comb begin
        busy_d = (next_state == S_SHIFT);
        done_d = (next_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= (sum >> 1) | y_msb;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) cout <= fa_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and exhaustive checks of the bit-serial adder at WIDTH=4.
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;

    int checks;
    int errors;

    serial_add_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drives one operation and observes a fixed window of negedges after the accepting edge.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                          input int window,
                          output int busy_n, output int done_n,
                          output logic [3:0] s, output logic c);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        busy_n = 0; done_n = 0; s = 'x; c = 1'bx;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                s = sum;
                c = cout;
            end
        end
    endtask

    vec_t       vt[7];
    int         bn, dn;
    logic [3:0] rs;
    logic       rc;
    logic [3:0] first_s, last_s;
    logic       first_c, last_c;
    logic [4:0] ref5;
    int         sweep_bad;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        vt[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0};
        vt[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vt[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vt[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vt[4] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vt[5] = '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1};
        vt[6] = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, 8, bn, dn, rs, rc);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vt[i].s));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vt[i].c));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'd4);
            chk($sformatf("vec%0d_done_pulses", i), 32'(dn), 32'd1);
            chk($sformatf("vec%0d_held_sum", i), 32'(sum), 32'(vt[i].s));
            chk($sformatf("vec%0d_idle", i), 32'(dut.state), 32'(S_IDLE));
        end

        // start held for 10 edges; inputs disturbed during SHIFT, then a new operand set
        // is presented so the re-accepted op in IDLE is distinguishable.
        @(negedge clk);
        a = 4'd4; b = 4'd2; cin = 1'b1; start = 1'b1;
        bn = 0; dn = 0; first_s = 'x; first_c = 1'bx; last_s = 'x; last_c = 1'bx;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i >= 9) start = 1'b0;
            if (i < 4) begin
                a = ~a; b = b + 4'd3; cin = ~cin;
            end else begin
                a = 4'd2; b = 4'd9; cin = 1'b1;
            end
            if (busy) bn++;
            if (done) begin
                if (dn == 0) begin first_s = sum; first_c = cout; end
                last_s = sum; last_c = cout;
                dn++;
            end
        end
        start = 1'b0;
        chk("held_first_sum", 32'(first_s), 32'd7);
        chk("held_first_cout", 32'(first_c), 32'd0);
        chk("held_done_pulses", 32'(dn), 32'd2);
        chk("held_busy_cycles", 32'(bn), 32'd8);
        chk("held_second_sum", 32'(last_s), 32'd12);
        chk("held_second_cout", 32'(last_c), 32'd0);

        // Abort mid-SHIFT with an asynchronous reset pulse.
        @(negedge clk);
        a = 4'd9; b = 4'd9; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_state", 32'(dut.state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_sum_after", 32'(sum), 32'd0);
        run_op(4'd6, 4'd7, 1'b0, 8, bn, dn, rs, rc);
        chk("after_abort_sum", 32'(rs), 32'd13);
        chk("after_abort_cout", 32'(rc), 32'd0);
        chk("after_abort_done", 32'(dn), 32'd1);

        sweep_bad = 0;
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            ref5 = 5'(vv[3:0]) + 5'(vv[7:4]) + 5'(vv[8]);
            run_op(vv[3:0], vv[7:4], vv[8], 6, bn, dn, rs, rc);
            chk($sformatf("sweep_%0d_result", v), 32'({rc, rs}), 32'(ref5));
            chk($sformatf("sweep_%0d_done", v), 32'(dn), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
